video_frame_guard: RTL

Frame-integrity stage between the video source mux output and the AXI VDMA S2MM port. It guarantees that every frame delivered downstream has exactly the configured width and height, and that every frame starts with TUSER (SOF). Short lines and short frames are padded with a fixed pixel. Long lines are truncated, extra lines are dropped, and data before a SOF is discarded. This keeps the VDMA from losing frame lock when the BT.656 receiver or test-pattern source is switched or glitches mid-frame.

---
 rtl/video_frame_guard_pkg.sv | 32 +++
 rtl/video_frame_guard_if.sv | 21 ++
 rtl/video_frame_guard_oreg.sv | 47 ++++
 rtl/video_frame_guard.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_frame_guard_pkg.sv
// ============================================================================
// Module      : video_ctrl_pkg
// Description : Shared types and constants for the video frame guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_ctrl_pkg;

  // Frame guard sequencing states
  typedef enum logic [2:0] {
    SEEK_SOF  = 3'd0,
    PASS      = 3'd1,
    PAD_LINE  = 3'd2,
    DROP_LINE = 3'd3,
    PAD_FRAME = 3'd4
  } frame_guard_state_t;

  // Black in YUV422 (Y=0x10, C=0x80)
  localparam logic [15:0] PAD_VAL_DEFAULT = 16'h8010;

  // Width of the statistics counters
  localparam int STAT_W = 16;

  // Increment that sticks at all-ones
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_frame_guard_if.sv
// ============================================================================
// Module      : video_frame_guard_if
// Description : AXI4-Stream video bus (pixel, valid/ready, SOF, EOL).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface video_frame_guard_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/video_frame_guard_oreg.sv
// ============================================================================
// Module      : video_frame_guard_oreg
// Description : One-entry AXI-S output register. Loads when empty or when
//               the current beat is being taken; holds otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_frame_guard_oreg #(
  parameter int DW = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          push,
  input  wire logic [DW-1:0] in_data,
  input  wire logic          in_user,
  input  wire logic          in_last,
  input  wire logic          out_ready,
  output logic               load,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic               out_user,
  output logic               out_last
);

  assign load = !out_valid || out_ready;

  // Output beat register: payload only changes when a new beat is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= push;
      if (push) begin
        out_data <= in_data;
        out_user <= in_user;
        out_last <= in_last;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/video_frame_guard.sv
// ============================================================================
// Module      : video_frame_guard
// Description : Forces every output frame to cfg_width x cfg_height with SOF
//               on the first pixel. Pads short lines/frames, truncates long
//               lines, drops extra lines and pre-SOF data.
//               Optional macro VIDEO_FRAME_GUARD_STATS_EN enables the
//               frame/repair statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_frame_guard
  import video_ctrl_pkg::*;
#(
  parameter int            DW      = 16,
  parameter int            WW      = 11,
  parameter logic [DW-1:0] PAD_VAL = DW'(PAD_VAL_DEFAULT)
) (
  input  wire logic              axi_clk_i,
  input  wire logic              axi_rst_i,
  input  wire logic              cfg_en_i,
  input  wire logic [WW-1:0]     cfg_width_i,
  input  wire logic [WW-1:0]     cfg_height_i,
  video_frame_guard_if.slave     s_axis,
  video_frame_guard_if.master    m_axis,
  output logic [STAT_W-1:0]      stat_frames_o,
  output logic [STAT_W-1:0]      stat_errs_o
);

  frame_guard_state_t state, state_nx;
  logic [WW-1:0] x, y, w, h;
  logic [WW-1:0] x_nx, y_nx, w_nx, h_nx;
  logic [WW-1:0] w_last, h_last, x_adv, y_adv;
  logic          x_end, y_end, pos_user;
  logic          enabled, sof_x_end, sof_y_end;
  logic          load, push, out_user, out_last, s_ready;
  logic [DW-1:0] out_data;
  logic          err_set, frame_done;
  logic          m_valid, m_user, m_last;
  logic [DW-1:0] m_data;

  assign enabled   = cfg_en_i && (cfg_width_i != '0) && (cfg_height_i != '0);
  assign sof_x_end = (cfg_width_i == WW'(1));
  assign sof_y_end = (cfg_height_i == WW'(1));

  // Position bookkeeping for the beat about to be emitted at (x,y)
  assign w_last   = w - WW'(1);
  assign h_last   = h - WW'(1);
  assign x_end    = (x == w_last);
  assign y_end    = (y == h_last);
  assign pos_user = (x == '0) && (y == '0);
  assign x_adv    = x_end ? '0 : x + WW'(1);
  assign y_adv    = x_end ? (y_end ? '0 : y + WW'(1)) : y;

  // State, position and latched geometry registers
  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) begin
      state <= SEEK_SOF;
      x     <= '0;
      y     <= '0;
      w     <= '0;
      h     <= '0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      y     <= y_nx;
      w     <= w_nx;
      h     <= h_nx;
    end
  end

  // Next-state, input ready and output beat selection
  always_comb begin
    state_nx   = state;
    x_nx       = x;
    y_nx       = y;
    w_nx       = w;
    h_nx       = h;
    s_ready    = 1'b0;
    push       = 1'b0;
    out_data   = s_axis.tdata;
    out_user   = 1'b0;
    out_last   = 1'b0;
    err_set    = 1'b0;
    frame_done = 1'b0;
    case (state)
      SEEK_SOF: begin
        // A SOF that must be forwarded waits for room; everything else is dropped
        s_ready = !(s_axis.tuser && enabled) || load;
        if (s_axis.tvalid && !s_axis.tuser) err_set = 1'b1;
        if (s_axis.tvalid && s_axis.tuser && enabled && load) begin
          w_nx     = cfg_width_i;
          h_nx     = cfg_height_i;
          push     = 1'b1;
          out_user = 1'b1;
          out_last = sof_x_end;
          if (!sof_x_end) begin
            x_nx = WW'(1);
            y_nx = '0;
            if (s_axis.tlast) begin
              state_nx = PAD_LINE;
              err_set  = 1'b1;
            end else begin
              state_nx = PASS;
            end
          end else if (sof_y_end) begin
            x_nx       = '0;
            y_nx       = '0;
            frame_done = 1'b1;
          end else begin
            x_nx = '0;
            y_nx = WW'(1);
            if (s_axis.tlast) begin
              state_nx = PASS;
            end else begin
              state_nx = DROP_LINE;
              err_set  = 1'b1;
            end
          end
        end
      end
      PASS: begin
        // An early SOF is held off and the frame is completed with padding
        s_ready = load && !s_axis.tuser;
        if (s_axis.tvalid && s_axis.tuser) begin
          state_nx = PAD_FRAME;
          err_set  = 1'b1;
        end else if (s_axis.tvalid && load) begin
          push       = 1'b1;
          out_user   = pos_user;
          out_last   = x_end;
          x_nx       = x_adv;
          y_nx       = y_adv;
          frame_done = x_end && y_end;
          if (x_end) begin
            if (y_end) begin
              state_nx = SEEK_SOF;
            end else if (!s_axis.tlast) begin
              state_nx = DROP_LINE;
              err_set  = 1'b1;
            end
          end else if (s_axis.tlast) begin
            state_nx = PAD_LINE;
            err_set  = 1'b1;
          end
        end
      end
      PAD_LINE: begin
        if (load) begin
          push     = 1'b1;
          out_data = PAD_VAL;
          out_last = x_end;
          x_nx     = x_adv;
          y_nx     = y_adv;
          frame_done = x_end && y_end;
          if (x_end) state_nx = y_end ? SEEK_SOF : PASS;
        end
      end
      DROP_LINE: begin
        s_ready = !s_axis.tuser;
        if (s_axis.tvalid) begin
          if (s_axis.tuser)      state_nx = PAD_FRAME;
          else if (s_axis.tlast) state_nx = PASS;
        end
      end
      PAD_FRAME: begin
        if (load) begin
          push       = 1'b1;
          out_data   = PAD_VAL;
          out_user   = pos_user;
          out_last   = x_end;
          x_nx       = x_adv;
          y_nx       = y_adv;
          frame_done = x_end && y_end;
          if (x_end && y_end) state_nx = SEEK_SOF;
        end
      end
      default: state_nx = SEEK_SOF;
    endcase
  end

  video_frame_guard_oreg #(
    .DW (DW)
  ) u_oreg (
    .clk       (axi_clk_i),
    .rst       (axi_rst_i),
    .push      (push),
    .in_data   (out_data),
    .in_user   (out_user),
    .in_last   (out_last),
    .out_ready (m_axis.tready),
    .load      (load),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_user  (m_user),
    .out_last  (m_last)
  );

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = m_data;
  assign m_axis.tuser  = m_user;
  assign m_axis.tlast  = m_last;

`ifdef VIDEO_FRAME_GUARD_STATS_EN
  logic err_flag;

  // Frame and repair counters; a repair seen in the gap rides with the next frame
  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) begin
      stat_frames_o <= '0;
      stat_errs_o   <= '0;
      err_flag      <= 1'b0;
    end else if (frame_done) begin
      stat_frames_o <= sat_inc(stat_frames_o);
      if (err_flag || err_set) stat_errs_o <= sat_inc(stat_errs_o);
      err_flag <= 1'b0;
    end else if (err_set) begin
      err_flag <= 1'b1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats  = ^{err_set, frame_done};
  assign stat_frames_o = '0;
  assign stat_errs_o   = '0;
`endif

endmodule

`default_nettype wire
